// File: rtl/i2c_axi_req_arbiter_if.sv
// AXI-Lite link between the request arbiter (master) and the I2C master wrapper (slave).
interface i2c_axi_req_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/i2c_axi_req_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite I2C master between NUM_REQ requesters.
// Optional i2c_irq watchdog with abort is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_axi_req_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rnw,
  input  logic [NUM_REQ*7-1:0] req_dev,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  input  logic                 i2c_irq,
  i2c_axi_req_arbiter_if.master m_axi
);
  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW   = C_M_AXI_ADDR_WIDTH;
  localparam int DW   = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, W_DEV, W_TXD, W_CTRL, WAIT_IRQ, R_STAT, DONE} state_t;

  state_t          state, state_n;
  logic [IDXW-1:0] last_gnt, idx, sel, pos;
  logic            found;
  logic            lat_rnw;
  logic [6:0]      lat_dev;
  logic [7:0]      lat_wdata;
  logic            aw_done, w_done, ar_done;
  logic [7:0]      rx_byte;
  logic            nack, axi_err, timed_out, timeout_hit;
  logic            in_write, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic            unused_rdata;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || state != WAIT_IRQ) cnt <= '0;
    else                           cnt <= cnt + 32'd1;
  end

  assign timeout_hit = (state == WAIT_IRQ) && !i2c_irq && (cnt == 32'(TIMEOUT_CYCLES));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // First pending requester strictly after the last grant, wrapping around.
  always_comb begin
    sel   = last_gnt;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDXW'((int'(last_gnt) + k) % NUM_REQ);
      if (!found && req[pos]) begin
        found = 1'b1;
        sel   = pos;
      end
    end
  end

  assign in_write = (state == W_DEV) || (state == W_TXD) || (state == W_CTRL);

  assign m_axi.awvalid = in_write && !aw_done;
  assign m_axi.wvalid  = in_write && !w_done;
  assign m_axi.bready  = in_write && aw_done && w_done;
  assign m_axi.arvalid = (state == R_STAT) && !ar_done;
  assign m_axi.rready  = (state == R_STAT) && ar_done;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.wstrb   = '1;
  assign m_axi.araddr  = AW'(4'hC);

  assign aw_hs = m_axi.awvalid && m_axi.awready;
  assign w_hs  = m_axi.wvalid  && m_axi.wready;
  assign b_hs  = m_axi.bvalid  && m_axi.bready;
  assign ar_hs = m_axi.arvalid && m_axi.arready;
  assign r_hs  = m_axi.rvalid  && m_axi.rready;

  assign unused_rdata = ^m_axi.rdata[DW-1:9];

  // After a watchdog expiry the CTRL write carries 0 to abort the peripheral.
  always_comb begin
    m_axi.awaddr = '0;
    m_axi.wdata  = '0;
    unique case (state)
      W_DEV:  m_axi.wdata = DW'({lat_rnw, lat_dev});
      W_TXD: begin
        m_axi.awaddr = AW'(4'h4);
        m_axi.wdata  = DW'(lat_wdata);
      end
      W_CTRL: begin
        m_axi.awaddr = AW'(4'h8);
        m_axi.wdata  = DW'(!timed_out);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:     if (found) state_n = W_DEV;
      W_DEV:    if (b_hs) state_n = lat_rnw ? W_CTRL : W_TXD;
      W_TXD:    if (b_hs) state_n = W_CTRL;
      W_CTRL:   if (b_hs) state_n = timed_out ? R_STAT : WAIT_IRQ;
      WAIT_IRQ: begin
        if (i2c_irq)          state_n = R_STAT;
        else if (timeout_hit) state_n = W_CTRL;
      end
      R_STAT:   if (r_hs) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt  <= IDXW'(NUM_REQ - 1);
      idx       <= '0;
      lat_rnw   <= 1'b0;
      lat_dev   <= '0;
      lat_wdata <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      ar_done   <= 1'b0;
      rx_byte   <= '0;
      nack      <= 1'b0;
      axi_err   <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          idx       <= sel;
          lat_rnw   <= req_rnw[sel];
          lat_dev   <= req_dev[sel*7 +: 7];
          lat_wdata <= req_wdata[sel*8 +: 8];
          rx_byte   <= '0;
          nack      <= 1'b0;
          axi_err   <= 1'b0;
          timed_out <= 1'b0;
        end
        W_DEV, W_TXD, W_CTRL: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if (b_hs) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (m_axi.bresp != 2'b00) axi_err <= 1'b1;
          end
        end
        WAIT_IRQ: if (timeout_hit) timed_out <= 1'b1;
        R_STAT: begin
          if (ar_hs) ar_done <= 1'b1;
          if (r_hs) begin
            ar_done <= 1'b0;
            rx_byte <= m_axi.rdata[7:0];
            nack    <= m_axi.rdata[8];
            if (m_axi.rresp != 2'b00) axi_err <= 1'b1;
          end
        end
        DONE: last_gnt <= idx;
        default: ;
      endcase
    end
  end

  // Write transactions and aborted ones always return a zero data byte.
  always_comb begin
    done      = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (state == DONE) begin
      done[idx] = 1'b1;
      rsp_rdata = (lat_rnw && !timed_out) ? rx_byte : 8'h00;
      rsp_err   = nack | axi_err | timed_out;
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_i2c_axi_req_arbiter.sv
// Directed testbench for i2c_axi_req_arbiter with a behavioural AXI-Lite I2C peripheral model.
`timescale 1ns/1ps
module tb_i2c_axi_req_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_rnw = '0;
  logic [27:0] req_dev = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  done;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        i2c_irq;

  int n_cmp = 0;
  int n_err = 0;

  i2c_axi_req_arbiter_if #(.ADDR_W(4), .DATA_W(32)) axi ();

  i2c_axi_req_arbiter #(
    .NUM_REQ(4), .C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_rnw(req_rnw), .req_dev(req_dev),
    .req_wdata(req_wdata), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .i2c_irq(i2c_irq), .m_axi(axi)
  );

  always #5 clk = ~clk;

  // Peripheral model knobs and state
  int          aw_lat = 0, w_lat = 0, b_lat = 0, irq_delay = 0;
  logic [1:0]  bresp_ctrl = 2'b00;
  logic [31:0] stat_val = '0;
  logic        irq_force = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, irq_cnt = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, r_pend = 1'b0, irq_arm = 1'b0, irq_q = 1'b0;
  logic [3:0]  cur_awaddr = '0;
  logic [31:0] cur_wdata = '0;
  logic [3:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  rd_addr_q[$];
  int          done_pulses = 0;

  assign axi.awready = axi.awvalid && (aw_cnt >= aw_lat);
  assign axi.wready  = axi.wvalid && (w_cnt >= w_lat);
  assign axi.bvalid  = aw_got && w_got && (b_cnt >= b_lat);
  assign axi.bresp   = (cur_awaddr == 4'h8) ? bresp_ctrl : 2'b00;
  assign axi.arready = axi.arvalid;
  assign axi.rvalid  = r_pend;
  assign axi.rdata   = stat_val;
  assign axi.rresp   = 2'b00;
  assign i2c_irq     = irq_q | irq_force;

  always @(posedge clk) begin
    if (!rst) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
      irq_arm <= 1'b0; irq_q <= 1'b0; irq_cnt <= 0;
    end else begin
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
      if (axi.awvalid && axi.awready) begin aw_got <= 1'b1; cur_awaddr <= axi.awaddr; end
      if (axi.wvalid && axi.wready)   begin w_got <= 1'b1;  cur_wdata <= axi.wdata;   end
      if (aw_got && w_got && !axi.bvalid) b_cnt <= b_cnt + 1;
      if (irq_arm) begin
        if (irq_cnt == 0) begin irq_q <= 1'b1; irq_arm <= 1'b0; end
        else irq_cnt <= irq_cnt - 1;
      end
      if (axi.bvalid && axi.bready) begin
        wr_addr_q.push_back(cur_awaddr);
        wr_data_q.push_back(cur_wdata);
        aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
        if (cur_awaddr == 4'h8 && cur_wdata[0]) begin irq_arm <= 1'b1; irq_cnt <= irq_delay; end
      end
      if (axi.arvalid && axi.arready) begin r_pend <= 1'b1; rd_addr_q.push_back(axi.araddr); end
      if (axi.rvalid && axi.rready) begin r_pend <= 1'b0; irq_q <= 1'b0; end
    end
  end

  always @(negedge clk) if (done != 4'b0000) done_pulses <= done_pulses + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input int k, input logic [31:0] addr, input logic [31:0] data);
    check_output({tag, "_addr"}, (k < wr_addr_q.size()) ? 32'(wr_addr_q[k]) : 32'hDEAD_BEEF, addr);
    check_output({tag, "_data"}, (k < wr_data_q.size()) ? wr_data_q[k] : 32'hDEAD_BEEF, data);
  endtask

  task automatic apply_stimulus(input int i, input logic rnw, input logic [6:0] dev, input logic [7:0] wd);
    req_rnw[i]          = rnw;
    req_dev[i*7 +: 7]   = dev;
    req_wdata[i*8 +: 8] = wd;
    req[i]              = 1'b1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic wait_done(input int limit, output logic ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      cycles++;
      if (done != 4'b0000) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    logic       ok;
    int         lat;
    logic [3:0] rr_exp [5];
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_rsp", 32'({rsp_err, rsp_rdata}), 32'd0);
    check_output("reset_valids", 32'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Write path
    irq_delay = 20; stat_val = 32'h000;
    clear_logs();
    apply_stimulus(0, 1'b0, 7'h50, 8'hA5);
    wait_done(200, ok, lat);
    check_output("wr_done_seen", 32'(ok), 32'd1);
    check_output("wr_done_vec", 32'(done), 32'h1);
    check_output("wr_rsp_err", 32'(rsp_err), 32'd0);
    check_output("wr_rsp_rdata", 32'(rsp_rdata), 32'h0);
    req[0] = 1'b0;
    @(negedge clk);
    check_output("wr_busy_after", 32'(busy), 32'd0);
    check_output("wr_nwrites", 32'(wr_addr_q.size()), 32'd3);
    check_write("wr_dev", 0, 32'h0, 32'h50);
    check_write("wr_txd", 1, 32'h4, 32'hA5);
    check_write("wr_ctrl", 2, 32'h8, 32'h1);
    check_output("wr_nreads", 32'(rd_addr_q.size()), 32'd1);
    check_output("wr_read_addr", (rd_addr_q.size() > 0) ? 32'(rd_addr_q[0]) : 32'hDEAD_BEEF, 32'hC);

    // Read path
    stat_val = 32'h03C;
    clear_logs();
    apply_stimulus(2, 1'b1, 7'h68, 8'h00);
    wait_done(200, ok, lat);
    check_output("rd_done_seen", 32'(ok), 32'd1);
    check_output("rd_done_vec", 32'(done), 32'h4);
    check_output("rd_rsp_rdata", 32'(rsp_rdata), 32'h3C);
    check_output("rd_rsp_err", 32'(rsp_err), 32'd0);
    req[2] = 1'b0;
    @(negedge clk);
    check_output("rd_nwrites", 32'(wr_addr_q.size()), 32'd2);
    check_write("rd_dev", 0, 32'h0, 32'hE8);
    check_write("rd_ctrl", 1, 32'h8, 32'h1);

    // NACK
    stat_val = 32'h100;
    clear_logs();
    apply_stimulus(1, 1'b1, 7'h20, 8'h00);
    wait_done(200, ok, lat);
    check_output("nack_done_seen", 32'(ok), 32'd1);
    check_output("nack_done_vec", 32'(done), 32'h2);
    check_output("nack_rsp_err", 32'(rsp_err), 32'd1);
    check_output("nack_rsp_rdata", 32'(rsp_rdata), 32'h00);
    req[1] = 1'b0;
    @(negedge clk);
    check_write("nack_dev", 0, 32'h0, 32'hA0);

    // AXI ordering: W accepted first, AW three cycles later, slow B, SLVERR on CTRL
    stat_val = 32'h000; aw_lat = 3; w_lat = 0; b_lat = 5; bresp_ctrl = 2'b10; irq_delay = 2;
    clear_logs();
    apply_stimulus(3, 1'b0, 7'h3A, 8'h5C);
    @(negedge clk);
    check_output("ord_both_valid", 32'({axi.awvalid, axi.wvalid}), 32'b11);
    @(negedge clk);
    check_output("ord_w_dropped", 32'({axi.awvalid, axi.wvalid}), 32'b10);
    wait_done(400, ok, lat);
    check_output("ord_done_seen", 32'(ok), 32'd1);
    check_output("ord_done_vec", 32'(done), 32'h8);
    check_output("ord_rsp_err", 32'(rsp_err), 32'd1);
    check_output("ord_rsp_rdata", 32'(rsp_rdata), 32'h00);
    req[3] = 1'b0;
    @(negedge clk);
    check_output("ord_nwrites", 32'(wr_addr_q.size()), 32'd3);
    check_write("ord_txd", 1, 32'h4, 32'h5C);
    check_write("ord_ctrl", 2, 32'h8, 32'h1);
    aw_lat = 0; b_lat = 0; bresp_ctrl = 2'b00;

    // Minimum latency: zero-wait AXI, irq already high, read path.
    // done appears on the 8th edge after req is set, i.e. the 9th cycle req is visible.
    irq_force = 1'b1; irq_delay = 0; stat_val = 32'h055;
    clear_logs();
    apply_stimulus(0, 1'b1, 7'h11, 8'h00);
    wait_done(50, ok, lat);
    check_output("lat_done_seen", 32'(ok), 32'd1);
    check_output("lat_cycles", 32'(lat), 32'd8);
    check_output("lat_done_vec", 32'(done), 32'h1);
    check_output("lat_rsp_rdata", 32'(rsp_rdata), 32'h55);
    req[0] = 1'b0;
    irq_force = 1'b0;
    @(negedge clk);

    // Round-robin from reset with all four requesters held high
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stat_val = 32'h000; irq_delay = 2;
    apply_stimulus(0, 1'b0, 7'h10, 8'h01);
    apply_stimulus(1, 1'b0, 7'h11, 8'h02);
    apply_stimulus(2, 1'b0, 7'h12, 8'h03);
    apply_stimulus(3, 1'b0, 7'h13, 8'h04);
    for (int k = 0; k < 5; k++) begin
      wait_done(200, ok, lat);
      check_output($sformatf("rr_done_seen_%0d", k), 32'(ok), 32'd1);
      check_output($sformatf("rr_grant_%0d", k), 32'(done), 32'(rr_exp[k]));
    end
    req = 4'b0000;
    @(negedge clk);
    check_output("rr_busy_after", 32'(busy), 32'd0);

    // Reset while waiting for the interrupt
    irq_delay = 1000;
    clear_logs();
    apply_stimulus(1, 1'b0, 7'h33, 8'h77);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wr_addr_q.size() == 3) begin ok = 1'b1; break; end
    end
    check_output("mid_reached_wait", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    lat = done_pulses;
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    check_output("mid_busy", 32'(busy), 32'd0);
    check_output("mid_done", 32'(done), 32'd0);
    check_output("mid_valids", 32'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 32'd0);
    check_output("mid_rsp", 32'({rsp_err, rsp_rdata}), 32'd0);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check_output("mid_no_done", 32'(done_pulses), 32'(lat));

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: irq never arrives, CTRL=0 abort then STAT read
    irq_delay = 100000;
    clear_logs();
    apply_stimulus(2, 1'b0, 7'h44, 8'h99);
    wait_done(500, ok, lat);
    check_output("to_done_seen", 32'(ok), 32'd1);
    check_output("to_done_vec", 32'(done), 32'h4);
    check_output("to_rsp_err", 32'(rsp_err), 32'd1);
    check_output("to_rsp_rdata", 32'(rsp_rdata), 32'h00);
    check_output("to_waited", 32'(lat > 100), 32'd1);
    req[2] = 1'b0;
    @(negedge clk);
    check_output("to_nwrites", 32'(wr_addr_q.size()), 32'd4);
    check_write("to_ctrl", 2, 32'h8, 32'h1);
    check_write("to_abort", 3, 32'h8, 32'h0);
    check_output("to_nreads", 32'(rd_addr_q.size()), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_axi_req_arbiter.md
Name: i2c_axi_req_arbiter

Overview:
- Shares one AXI-Lite I2C master peripheral between NUM_REQ on-chip requesters.
- Round-robin selects one single-byte I2C transaction (read or write to a 7-bit device) per grant.
- Sequences the peripheral's register writes, waits for its interrupt, reads back status, and returns result plus error to the winning requester.
- Sits between client logic and the AXI-Lite slave port of the I2C master wrapper; drives that port as sole AXI-Lite master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- C_M_AXI_ADDR_WIDTH, 4, AXI-Lite address width; matches the I2C slave port.
- C_M_AXI_DATA_WIDTH, 32, AXI-Lite data width.
- TIMEOUT_CYCLES, 65535, i2c_irq watchdog limit (used only with I2C_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset.
- req  in  NUM_REQ  per-requester request, held until its done pulse.
- req_rnw  in  NUM_REQ  1 = I2C read, 0 = write.
- req_dev  in  NUM_REQ*7  7-bit device address, slice i for requester i.
- req_wdata  in  NUM_REQ*8  write byte, slice i.
- done  out  NUM_REQ  one-cycle completion pulse to granted requester.
- rsp_rdata  out  8  read byte, valid with done.
- rsp_err  out  1  NACK/timeout flag, valid with done.
- busy  out  1  transaction in progress.
- i2c_irq  in  1  level interrupt from I2C master, high on completion.
- m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready  AXI-Lite master channels; standard widths.

Behaviour:
- Peripheral register map (fixed):
  - 0x0 DEV: bits[6:0] device address, bit7 rnw.
  - 0x4 TXD: bits[7:0] write byte.
  - 0x8 CTRL: bit0 start.
  - 0xC STAT: bits[7:0] rx byte, bit8 nack; reading STAT clears i2c_irq.
- Reset values: all outputs 0 (awvalid, wvalid, bready, arvalid, rready, done, busy, rsp_*). Pointer last_gnt = NUM_REQ-1. State IDLE.
- FSM: IDLE -> W_DEV -> W_TXD -> W_CTRL -> WAIT_IRQ -> R_STAT -> DONE -> IDLE.
- IDLE:
  - If any req bit is set, pick the first set index after last_gnt, wrapping.
  - Latch that index and its rnw/dev/wdata into local registers; later changes on req_* are ignored. Set busy=1.
- AXI write states:
  - Assert awvalid and wvalid together in the same cycle; awprot = 0, wstrb = 4'hF.
  - Drop each valid independently on its own ready. Both may complete in the same cycle or in either order.
  - After both handshakes, assert bready until bvalid, then advance.
  - W_TXD is skipped (W_DEV -> W_CTRL) when rnw = 1.
- WAIT_IRQ: wait for i2c_irq = 1; no timeout unless the feature is enabled.
- R_STAT:
  - Assert arvalid with araddr = 0xC until arready, then rready until rvalid.
  - Capture rdata[7:0] and rdata[8].
  - Any bresp or rresp != OKAY anywhere in the sequence forces rsp_err = 1, but the sequence still completes.
- DONE, exactly one cycle:
  - done[idx] = 1; rsp_rdata = captured byte (0 on write); rsp_err = nack | axi_err.
  - last_gnt = idx; busy = 0 the following cycle.
- Minimum latency: request visible to done pulse = 9 cycles with zero-wait AXI and i2c_irq already high.
- A requester may drop req only after its done pulse. Re-asserting req in the cycle after done is legal, but round-robin grants another pending requester first.
- A request arriving mid-transaction waits; no preemption.
- rst low at any cycle:
  - Returns to IDLE immediately; all valids drop even mid-handshake; no done is issued.
  - The peripheral itself is reset from the same rst.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter runs in WAIT_IRQ, cleared on entry.
  - When it reaches TIMEOUT_CYCLES without i2c_irq: write CTRL = 0 (abort), go to R_STAT to clear state, then report rsp_err = 1 and rsp_rdata = 0.
- Undefined: no counter; WAIT_IRQ waits indefinitely.

Test Plan:
- Write path: req[0], rnw = 0, dev = 0x50, wdata = 0xA5; AXI zero-wait, irq after 20 cycles, STAT = 0x000 -> writes 0x0 = 0x50, 0x4 = 0xA5, 0x8 = 0x1; one read of 0xC; done[0] pulse with rsp_err = 0.
- Read path: req[2], rnw = 1, dev = 0x68; STAT returns 0x03C -> no write to 0x4; 0x0 written as 0xE8; done[2] with rsp_rdata = 0x3C, rsp_err = 0.
- NACK: STAT returns 0x100 -> rsp_err = 1, rsp_rdata = 0x00.
- Round-robin: req = 4'b1111 held continuously -> grant order 0,1,2,3,0 across consecutive transactions; exactly one done bit per transaction.
- AXI ordering: awready 3 cycles after wready, bvalid delayed 5 cycles, bresp = SLVERR on the W_CTRL write -> valids drop independently; final rsp_err = 1.
- Reset mid-WAIT_IRQ: rst = 0 for 1 cycle -> all outputs 0 next cycle, no done pulse; with I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 100 and irq never asserting -> CTRL = 0 written after 100 cycles, done with rsp_err = 1.
